// File: rtl/register_synchronizer.sv
// rtl/register_synchronizer.sv - multi-bit CDC synchronizer with optional stability filter and edge strobes
module register_synchronizer #(
  parameter int                   reg_width   = 1,
  parameter logic [reg_width-1:0] reg_preset  = '0,
  parameter int                   sync_stages = 2,
  parameter int                   filter_len  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [reg_width-1:0] reg_i,
  output logic [reg_width-1:0] reg_o,
  output logic [reg_width-1:0] rise_o,
  output logic [reg_width-1:0] fall_o,
  output logic                 change_o
);

  if (sync_stages < 2 || sync_stages > 8) begin : g_bad_stages
    $error("register_synchronizer: sync_stages must be 2..8");
  end
  if (reg_width < 1 || reg_width > 32) begin : g_bad_width
    $error("register_synchronizer: reg_width must be 1..32");
  end
  if (filter_len < 0 || filter_len > 255) begin : g_bad_filter
    $error("register_synchronizer: filter_len must be 0..255");
  end

  logic [reg_width-1:0] stage_q [sync_stages] = '{default: reg_preset};
  logic [reg_width-1:0] s_d;
  logic [reg_width-1:0] next_o;
  logic [reg_width-1:0] rise_q   = '0;
  logic [reg_width-1:0] fall_q   = '0;
  logic                 change_q = 1'b0;

  // Value the last stage takes on this enabled edge.
  assign s_d = stage_q[sync_stages-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < sync_stages; i++) stage_q[i] <= reg_preset;
    end else if (clk_en) begin
      stage_q[0] <= reg_i;
      for (int i = 1; i < sync_stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  if (filter_len == 0) begin : g_bypass
    assign next_o = s_d;
    assign reg_o  = stage_q[sync_stages-1];
  end else begin : g_filter
    localparam logic [7:0] FLT = 8'(filter_len);

    logic [reg_width-1:0] cand_q = reg_preset;
    logic [reg_width-1:0] cand_d;
    logic [7:0]           cnt_q  = 8'd0;
    logic [7:0]           cnt_d;
    logic [reg_width-1:0] out_q  = reg_preset;
    logic [reg_width-1:0] out_d;

    // The candidate tracks the value entering the last stage, so a clean
    // step reaches reg_o sync_stages+filter_len+1 enabled edges after reg_i.
    always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      if (s_d != cand_q) begin
        cand_d = s_d;
        cnt_d  = 8'd0;
      end else begin
        if (cnt_q < FLT) cnt_d = cnt_q + 8'd1;
        if (cnt_q == FLT) out_d = cand_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cand_q <= reg_preset;
        cnt_q  <= 8'd0;
        out_q  <= reg_preset;
      end else if (clk_en) begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
      end
    end

    assign next_o = out_d;
    assign reg_o  = out_q;
  end

  // Strobes drop on any disabled edge so none lasts longer than one clock.
  always_ff @(posedge clk) begin
    if (rst || !clk_en) begin
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      rise_q   <= next_o & ~reg_o;
      fall_q   <= ~next_o & reg_o;
      change_q <= |(next_o ^ reg_o);
    end
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_register_synchronizer.sv
// tb/tb_register_synchronizer.sv - directed bench for register_synchronizer
module tb_register_synchronizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b1;

  logic [3:0]  a_i = 4'h5, a_o, a_r, a_f;
  logic        a_c;
  logic        b_i = 1'b0, b_o, b_r, b_f, b_c;
  logic [31:0] c_i = '0, c_o, c_r, c_f;
  logic        c_c;
  logic        d_i = 1'b0, d_o, d_r, d_f, d_c;
  logic [31:0] e_i = '0, e_o, e_r, e_f;
  logic        e_c;
  logic        g_i = 1'b0, g_o, g_r, g_f, g_c;

  register_synchronizer #(.reg_width(4), .reg_preset(4'hA), .sync_stages(2), .filter_len(0)) u_a (
    .clk(clk), .rst(rst), .clk_en(en), .reg_i(a_i), .reg_o(a_o), .rise_o(a_r), .fall_o(a_f), .change_o(a_c));
  register_synchronizer #(.reg_width(1), .reg_preset(1'b0), .sync_stages(2), .filter_len(3)) u_b (
    .clk(clk), .rst(rst), .clk_en(en), .reg_i(b_i), .reg_o(b_o), .rise_o(b_r), .fall_o(b_f), .change_o(b_c));
  register_synchronizer #(.reg_width(32), .reg_preset(32'h0), .sync_stages(8), .filter_len(0)) u_c (
    .clk(clk), .rst(rst), .clk_en(en), .reg_i(c_i), .reg_o(c_o), .rise_o(c_r), .fall_o(c_f), .change_o(c_c));
  register_synchronizer #(.reg_width(1), .reg_preset(1'b0), .sync_stages(8), .filter_len(0)) u_d (
    .clk(clk), .rst(rst), .clk_en(en), .reg_i(d_i), .reg_o(d_o), .rise_o(d_r), .fall_o(d_f), .change_o(d_c));
  register_synchronizer #(.reg_width(32), .reg_preset(32'h0), .sync_stages(2), .filter_len(0)) u_e (
    .clk(clk), .rst(rst), .clk_en(en), .reg_i(e_i), .reg_o(e_o), .rise_o(e_r), .fall_o(e_f), .change_o(e_c));
  register_synchronizer #(.reg_width(1), .reg_preset(1'b0), .sync_stages(2), .filter_len(0)) u_g (
    .clk(clk), .rst(rst), .clk_en(en), .reg_i(g_i), .reg_o(g_o), .rise_o(g_r), .fall_o(g_f), .change_o(g_c));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] in;
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
    logic       c;
  } vec_t;

  vec_t tbl [20];

  logic [31:0] hc [64];
  logic [31:0] he [64];
  logic        hd [64];
  logic        hg [64];

  initial begin
    // rst en  in     reg_o  rise   fall   chg
    tbl[0]  = '{1'b1, 1'b1, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'h5, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h3, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h3, 4'h3, 4'h1, 4'h8, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'hC, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'hC, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'hC, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'hC, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'hC, 4'hC, 4'hC, 4'h3, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'hC, 4'hC, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h5, 4'hC, 4'h0, 4'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h5, 4'h5, 4'h1, 4'h8, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'h6, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 4'h6, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 4'h6, 4'hA, 4'h0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 4'h6, 4'h6, 4'h4, 4'h8, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 4'h6, 4'h6, 4'h0, 4'h0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      en  = tbl[i].en;
      a_i = tbl[i].in;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d reg_o", i),    32'(a_o), 32'(tbl[i].o));
      chk($sformatf("row%0d rise_o", i),   32'(a_r), 32'(tbl[i].r));
      chk($sformatf("row%0d fall_o", i),   32'(a_f), 32'(tbl[i].f));
      chk($sformatf("row%0d change_o", i), 32'(a_c), 32'(tbl[i].c));
    end

    // Width/depth sweep: random vector every edge, reg_o lags by sync_stages.
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    c_i = '0; d_i = 1'b0; e_i = '0; g_i = 1'b0;
    @(posedge clk);
    #1;
    chk("sweep reset c_o", c_o, 32'h0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      rst = 1'b0;
      c_i = $urandom;
      e_i = $urandom;
      d_i = 1'($urandom);
      g_i = 1'($urandom);
      hc[n] = c_i; he[n] = e_i; hd[n] = d_i; hg[n] = g_i;
      @(posedge clk);
      #1;
      chk($sformatf("sweep w32s8 n%0d", n), c_o, (n >= 8) ? hc[n-7] : 32'h0);
      chk($sformatf("sweep w1s8 n%0d", n),  32'(d_o), (n >= 8) ? 32'(hd[n-7]) : 32'h0);
      chk($sformatf("sweep w32s2 n%0d", n), e_o, (n >= 2) ? he[n-1] : 32'h0);
      chk($sformatf("sweep w1s2 n%0d", n),  32'(g_o), (n >= 2) ? 32'(hg[n-1]) : 32'h0);
    end

    // Filter: a short glitch is swallowed, a sustained level passes once.
    @(negedge clk);
    rst = 1'b1; b_i = 1'b0;
    @(posedge clk);
    #1;
    chk("flt reset reg_o", 32'(b_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      b_i = (k == 1 || k == 2);
      @(posedge clk);
      #1;
      chk($sformatf("flt glitch k%0d reg_o", k), 32'(b_o), 32'h0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b_i = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("flt settle k%0d reg_o", k), 32'(b_o), 32'h0);
      chk($sformatf("flt settle k%0d rise_o", k), 32'(b_r), 32'h0);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      b_i = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("flt step k%0d reg_o", k),  32'(b_o), (k >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("flt step k%0d rise_o", k), 32'(b_r), (k == 6) ? 32'h1 : 32'h0);
      chk($sformatf("flt step k%0d change_o", k), 32'(b_c), (k == 6) ? 32'h1 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
